memory_port_arbiter: RTL
========================

# memory_port_arbiter

Shares the processor's single-ported unified memory between the instruction-fetch stage and the load/store (MEM) stage. Accepts one request at a time, sequences the fixed-latency memory access, returns data with a one-cycle acknowledge, and drives the fetch and memory stall lines consumed by the pipeline control. Data accesses have priority; a streak counter guarantees fetch progress. A branch flush cancels an in-flight fetch.

## Interface
- ADDR_W, 16, memory address width
- DATA_W, 16, memory word width
- MEM_LATENCY, 2, cycles from m_en to valid m_rdata (≥1)
- MAX_STREAK, 3, consecutive data grants allowed while fetch waits (≥1)

- clock  input  1  single clock, rising edge
- reset_n  input  1  asynchronous, active-low reset
- if_req  input  1  fetch request, held until if_ack or flush
- if_addr  input  ADDR_W  fetch address, stable while if_req
- if_ack  output  1  one-cycle fetch completion
- if_rdata  output  DATA_W  fetched word, valid with if_ack, held until next fetch ack
- mem_req  input  1  data request, held until mem_ack
- mem_we  input  1  1 = store, 0 = load
- mem_addr  input  ADDR_W  data address
- mem_wdata  input  DATA_W  store data
- mem_ack  output  1  one-cycle data completion
- mem_rdata  output  DATA_W  load data, valid with mem_ack, held until next data ack
- flush  input  1  branch taken; cancels outstanding fetch
- stall_fetch  output  1  if_req & ~if_ack
- stall_mem  output  1  mem_req & ~mem_ack
- m_en  output  1  memory access strobe, one cycle per transaction
- m_we  output  1  memory write enable, qualified by m_en
- m_addr  output  ADDR_W  memory address
- m_wdata  output  DATA_W  memory write data
- m_rdata  input  DATA_W  memory read data, valid MEM_LATENCY cycles after m_en

## Operation
- States: IDLE, ACCESS, WAIT, RESPOND.
- IDLE: if any request at a clock edge, latch owner (IF or DATA), address, we, wdata → ACCESS. No request → stay.
- Arbitration: mem_req wins over if_req, except when streak == MAX_STREAK and if_req is high → fetch wins.
- streak: +1 on each data grant made with if_req high; cleared on fetch grant or on data grant with if_req low; saturates at MAX_STREAK.
- ACCESS: m_en=1, m_we=owner DATA & latched we; m_addr/m_wdata from latch; latency counter loaded with MEM_LATENCY → WAIT.
- WAIT: counter decrements each cycle; at the edge ending the cycle where m_rdata is valid (MEM_LATENCY cycles after ACCESS), capture m_rdata into owner's rdata register (loads and fetches only; stores leave mem_rdata unchanged) → RESPOND.
- RESPOND: owner ack = 1 for exactly this cycle → IDLE unconditionally (requester drops req on the following edge; no re-arbitration in RESPOND).
- Flush: sampled at an edge in ACCESS or WAIT with owner IF → cancel flag set; transaction completes on memory; if_ack and if_rdata update suppressed in RESPOND. Flush in IDLE or RESPOND, or with owner DATA: no effect. cancel cleared on entry to IDLE.
- Stores and loads both acknowledge after full latency (uniform timing).
- m_en, m_we are 0 outside ACCESS; m_addr/m_wdata hold last value.

## Timing
- Reset (async, any state, mid-transaction included): state IDLE; m_en, m_we, if_ack, mem_ack, streak, cancel = 0; m_addr, m_wdata, if_rdata, mem_rdata = 0. In-flight transaction abandoned, no ack.
- Request seen in IDLE at edge of cycle 0 → m_en cycle 1 → rdata valid cycle 1+MEM_LATENCY → ack cycle 2+MEM_LATENCY → IDLE cycle 3+MEM_LATENCY. Default: ack in cycle 4; throughput one access per MEM_LATENCY+3 cycles.
- stall_fetch/stall_mem are combinational from inputs and registered acks; deassert in the ack cycle.
- Simultaneous if_req and mem_req in IDLE: one grant only; loser's stall stays high.

## Test plan
- Single load, mem_addr=0x0040, memory returns 0xBEEF at latency 2 → m_en cycle 1 with m_we=0, mem_ack cycle 4, mem_rdata=0xBEEF, stall_mem high cycles 0-3.
- Store 0x1234 to 0x0010 → m_en=m_we=1, m_wdata=0x1234 in cycle 1; mem_ack cycle 4; mem_rdata unchanged.
- if_req and mem_req held continuously, MAX_STREAK=3 → grant order DATA, DATA, DATA, IF, DATA…; if_ack after third data ack.
- Fetch in flight, flush pulsed in WAIT → m_en issued, no if_ack, if_rdata unchanged, FSM back in IDLE at cycle 3+MEM_LATENCY.
- Flush during a data transaction → mem_ack delivered normally.
- reset_n low during WAIT → all outputs zero immediately; after release, pending if_req granted from IDLE with full latency.

Source files
------------

// File: rtl/memory_port_arbiter_if.sv
// Bundle of the fetch, data and memory-side signals around the memory port arbiter.
// Requests (if_req/mem_req) are held high until the matching one-cycle ack or a flush; the ack cycle is the only completion event.
interface memory_port_arbiter_if #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 16
);
    logic              if_req;
    logic [ADDR_W-1:0] if_addr;
    logic              if_ack;
    logic [DATA_W-1:0] if_rdata;
    logic              mem_req;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic              mem_ack;
    logic [DATA_W-1:0] mem_rdata;
    logic              flush;
    logic              stall_fetch;
    logic              stall_mem;
    logic              m_en;
    logic              m_we;
    logic [ADDR_W-1:0] m_addr;
    logic [DATA_W-1:0] m_wdata;
    logic [DATA_W-1:0] m_rdata;

    modport slave (
        input  if_req, if_addr, mem_req, mem_we, mem_addr, mem_wdata, flush, m_rdata,
        output if_ack, if_rdata, mem_ack, mem_rdata, stall_fetch, stall_mem,
               m_en, m_we, m_addr, m_wdata
    );

    modport master (
        output if_req, if_addr, mem_req, mem_we, mem_addr, mem_wdata, flush, m_rdata,
        input  if_ack, if_rdata, mem_ack, mem_rdata, stall_fetch, stall_mem,
               m_en, m_we, m_addr, m_wdata
    );
endinterface

// File: rtl/memory_port_arbiter.sv
// Shares one fixed-latency memory port between instruction fetch and load/store,
// one transaction at a time, with data priority bounded by a fetch-starvation streak.
module memory_port_arbiter #(
    parameter int ADDR_W      = 16,
    parameter int DATA_W      = 16,
    parameter int MEM_LATENCY = 2,
    parameter int MAX_STREAK  = 3
) (
    input  logic                   clock,
    input  logic                   reset_n,
    memory_port_arbiter_if.slave   bus,
    output logic [1:0]             o_dbg_state
);

    localparam int CNT_W = $clog2(MEM_LATENCY + 1);
    localparam int STK_W = $clog2(MAX_STREAK + 1);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_ACCESS  = 2'd1,
        S_WAIT    = 2'd2,
        S_RESPOND = 2'd3
    } state_t;

    state_t            r_state;
    state_t            w_next;
    logic              r_owner_if;
    logic              r_we;
    logic              r_cancel;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_wdata;
    logic [DATA_W-1:0] r_if_rdata;
    logic [DATA_W-1:0] r_mem_rdata;
    logic [CNT_W-1:0]  r_cnt;
    logic [STK_W-1:0]  r_streak;

    logic w_any_req;
    logic w_grant_if;
    logic w_done;
    logic w_streak_full;

    // Fetch only beats a pending data request once data has won MAX_STREAK times in a row.
    assign w_streak_full = (r_streak == STK_W'(MAX_STREAK));
    assign w_any_req     = bus.if_req | bus.mem_req;
    assign w_grant_if    = bus.if_req & (~bus.mem_req | w_streak_full);
    assign w_done        = (r_state == S_WAIT) && (r_cnt == CNT_W'(1));

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) r_state <= S_IDLE;
        else          r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:    if (w_any_req) w_next = S_ACCESS;
            S_ACCESS:  w_next = S_WAIT;
            S_WAIT:    if (w_done) w_next = S_RESPOND;
            S_RESPOND: w_next = S_IDLE;
            default:   w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_owner_if  <= 1'b0;
            r_we        <= 1'b0;
            r_cancel    <= 1'b0;
            r_addr      <= '0;
            r_wdata     <= '0;
            r_if_rdata  <= '0;
            r_mem_rdata <= '0;
            r_cnt       <= '0;
            r_streak    <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_any_req) begin
                        r_owner_if <= w_grant_if;
                        if (w_grant_if) begin
                            r_addr   <= bus.if_addr;
                            r_we     <= 1'b0;
                            r_streak <= '0;
                        end else begin
                            r_addr  <= bus.mem_addr;
                            r_we    <= bus.mem_we;
                            r_wdata <= bus.mem_wdata;
                            if (!bus.if_req)        r_streak <= '0;
                            else if (!w_streak_full) r_streak <= r_streak + STK_W'(1);
                        end
                    end
                end
                S_ACCESS: begin
                    r_cnt <= CNT_W'(MEM_LATENCY);
                    if (r_owner_if && bus.flush) r_cancel <= 1'b1;
                end
                S_WAIT: begin
                    r_cnt <= r_cnt - CNT_W'(1);
                    if (r_owner_if && bus.flush) r_cancel <= 1'b1;
                    // A flush seen on the capture edge itself must also block the fetch update.
                    if (w_done) begin
                        if (r_owner_if) begin
                            if (!r_cancel && !bus.flush) r_if_rdata <= bus.m_rdata;
                        end else if (!r_we) begin
                            r_mem_rdata <= bus.m_rdata;
                        end
                    end
                end
                S_RESPOND: r_cancel <= 1'b0;
                default:   r_cancel <= 1'b0;
            endcase
        end
    end

    assign bus.m_en        = (r_state == S_ACCESS);
    assign bus.m_we        = (r_state == S_ACCESS) & ~r_owner_if & r_we;
    assign bus.m_addr      = r_addr;
    assign bus.m_wdata     = r_wdata;
    assign bus.if_ack      = (r_state == S_RESPOND) & r_owner_if & ~r_cancel;
    assign bus.mem_ack     = (r_state == S_RESPOND) & ~r_owner_if;
    assign bus.if_rdata    = r_if_rdata;
    assign bus.mem_rdata   = r_mem_rdata;
    assign bus.stall_fetch = bus.if_req & ~bus.if_ack;
    assign bus.stall_mem   = bus.mem_req & ~bus.mem_ack;
    assign o_dbg_state     = r_state;

endmodule
